// File: rtl/payment_dispenser.sv
`default_nettype none
// ============================================================================
//  Module   : payment_dispenser
//  Purpose  : Consumer end of the product-selection interface. Latches the
//             selected product code and price, collects coins until credit
//             covers the price, dispenses, then pays change in CHANGE_UNIT
//             steps. Refunds credit when COLLECT sees no coin for
//             TIMEOUT_CYCLES cycles.
//  Config   : `define PAYMENT_CANCEL_EN adds the cancel_i port. A cancel in
//             COLLECT forces an immediate refund, and any coin offered in the
//             same cycle is rejected.
//  Ports    : clk                 rising-edge clock
//             rst_n               asynchronous active-low reset
//             price_valid_i       strobe, product_price_i/product_out_i valid
//             product_price_i[5]  price of the selected product
//             product_out_i[2]    selected product code
//             coin_valid_i        strobe, coin inserted
//             coin_type_i[2]      coin code (2'b00 invalid)
//             cancel_i            user cancel (PAYMENT_CANCEL_EN only)
//             ready_o             high in IDLE
//             credit_o[6]         current credit
//             coin_reject_o       1-cycle pulse, coin not accepted
//             dispense_valid_o    1-cycle pulse, release product
//             dispense_product_o  product code, valid with dispense_valid_o
//             change_pulse_o      one CHANGE_UNIT returned this cycle
//             refund_o            high in REFUND
//             timeout_flag_o      1-cycle pulse on COLLECT timeout
//  Revision : 1.0  initial release
// ============================================================================
module payment_dispenser #(
    parameter logic [1:0]  COIN_5_CODE    = 2'b01,
    parameter logic [1:0]  COIN_10_CODE   = 2'b10,
    parameter logic [1:0]  COIN_20_CODE   = 2'b11,
    parameter logic [5:0]  CHANGE_UNIT    = 6'd5,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       price_valid_i,
    input  logic [4:0] product_price_i,
    input  logic [1:0] product_out_i,
    input  logic       coin_valid_i,
    input  logic [1:0] coin_type_i,
`ifdef PAYMENT_CANCEL_EN
    input  logic       cancel_i,
`endif
    output logic       ready_o,
    output logic [5:0] credit_o,
    output logic       coin_reject_o,
    output logic       dispense_valid_o,
    output logic [1:0] dispense_product_o,
    output logic       change_pulse_o,
    output logic       refund_o,
    output logic       timeout_flag_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_DISPENSE = 3'd2,
        S_CHANGE   = 3'd3,
        S_REFUND   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  credit_q, credit_d;
    logic [4:0]  price_q, price_d;
    logic [1:0]  product_q, product_d;
    logic [15:0] timer_q, timer_d;
    logic        coin_reject_q, coin_reject_d;
    logic        timeout_q, timeout_d;

    logic        w_cancel;
    logic        w_coin_ok;
    logic [5:0]  w_coin_value;
    logic [5:0]  w_price_ext;

`ifdef PAYMENT_CANCEL_EN
    assign w_cancel = cancel_i;
`else
    assign w_cancel = 1'b0;
`endif

    assign w_price_ext = {1'b0, price_q};

    always_comb begin
        w_coin_ok    = 1'b0;
        w_coin_value = 6'd0;
        if (coin_type_i == COIN_5_CODE) begin
            w_coin_ok    = 1'b1;
            w_coin_value = 6'd5;
        end else if (coin_type_i == COIN_10_CODE) begin
            w_coin_ok    = 1'b1;
            w_coin_value = 6'd10;
        end else if (coin_type_i == COIN_20_CODE) begin
            w_coin_ok    = 1'b1;
            w_coin_value = 6'd20;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            credit_q      <= 6'd0;
            price_q       <= 5'd0;
            product_q     <= 2'd0;
            timer_q       <= 16'd0;
            coin_reject_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            price_q       <= price_d;
            product_q     <= product_d;
            timer_q       <= timer_d;
            coin_reject_q <= coin_reject_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        price_d       = price_q;
        product_d     = product_q;
        timer_d       = timer_q;
        coin_reject_d = 1'b0;
        timeout_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                coin_reject_d = coin_valid_i;
                if (price_valid_i && (product_price_i != 5'd0)) begin
                    price_d   = product_price_i;
                    product_d = product_out_i;
                    credit_d  = 6'd0;
                    timer_d   = 16'd0;
                    state_d   = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (w_cancel) begin
                    coin_reject_d = coin_valid_i;
                    timer_d       = 16'd0;
                    state_d       = S_REFUND;
                end else if (credit_q >= w_price_ext) begin
                    // Payment already complete: a late coin is not taken
                    coin_reject_d = coin_valid_i;
                    timer_d       = 16'd0;
                    state_d       = S_DISPENSE;
                end else if (coin_valid_i && w_coin_ok) begin
                    credit_d = credit_q + w_coin_value;
                    timer_d  = 16'd0;
                end else begin
                    // Invalid coin codes do not keep the session alive
                    coin_reject_d = coin_valid_i;
                    if (timer_q == (TIMEOUT_CYCLES - 16'd1)) begin
                        timer_d   = 16'd0;
                        timeout_d = 1'b1;
                        state_d   = S_REFUND;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
            end

            S_DISPENSE: begin
                coin_reject_d = coin_valid_i;
                credit_d      = credit_q - w_price_ext;
                state_d       = (credit_d != 6'd0) ? S_CHANGE : S_IDLE;
            end

            S_CHANGE, S_REFUND: begin
                coin_reject_d = coin_valid_i;
                if (credit_q >= CHANGE_UNIT) begin
                    credit_d = credit_q - CHANGE_UNIT;
                end else begin
                    // Residue smaller than one change unit is dropped
                    credit_d = 6'd0;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded purely from registered state
    assign ready_o            = (state_q == S_IDLE);
    assign credit_o           = credit_q;
    assign coin_reject_o      = coin_reject_q;
    assign dispense_valid_o   = (state_q == S_DISPENSE);
    assign dispense_product_o = (state_q == S_DISPENSE) ? product_q : 2'd0;
    assign change_pulse_o     = ((state_q == S_CHANGE) || (state_q == S_REFUND))
                                && (credit_q >= CHANGE_UNIT);
    assign refund_o           = (state_q == S_REFUND);
    assign timeout_flag_o     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_payment_dispenser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_payment_dispenser
//  Purpose  : Self-checking bench for payment_dispenser: directed scenarios
//             plus randomized traffic compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_payment_dispenser;

    localparam int TO = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       price_valid = 1'b0;
    logic [4:0] product_price = 5'd0;
    logic [1:0] product_out = 2'd0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'd0;
    logic       cancel = 1'b0;
    logic       ready;
    logic [5:0] credit;
    logic       coin_reject;
    logic       dispense_valid;
    logic [1:0] dispense_product;
    logic       change_pulse;
    logic       refund;
    logic       timeout_flag;

    int n_cmp = 0;
    int n_err = 0;

    payment_dispenser #(
        .COIN_5_CODE    (2'b01),
        .COIN_10_CODE   (2'b10),
        .COIN_20_CODE   (2'b11),
        .CHANGE_UNIT    (6'd5),
        .TIMEOUT_CYCLES (16'(TO))
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .price_valid_i      (price_valid),
        .product_price_i    (product_price),
        .product_out_i      (product_out),
        .coin_valid_i       (coin_valid),
        .coin_type_i        (coin_type),
`ifdef PAYMENT_CANCEL_EN
        .cancel_i           (cancel),
`endif
        .ready_o            (ready),
        .credit_o           (credit),
        .coin_reject_o      (coin_reject),
        .dispense_valid_o   (dispense_valid),
        .dispense_product_o (dispense_product),
        .change_pulse_o     (change_pulse),
        .refund_o           (refund),
        .timeout_flag_o     (timeout_flag)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, let one rising edge pass, land 1 ns after it
    task automatic tick(input logic pv, input logic [4:0] pp, input logic [1:0] pr,
                        input logic cv, input logic [1:0] ct, input logic cn);
        price_valid   = pv;
        product_price = pp;
        product_out   = pr;
        coin_valid    = cv;
        coin_type     = ct;
        cancel        = cn;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        price_valid = 1'b0; product_price = 5'd0; product_out = 2'd0;
        coin_valid = 1'b0; coin_type = 2'd0; cancel = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        price_valid = 1'b0; coin_valid = 1'b0; cancel = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({ready, credit, coin_reject, dispense_valid, dispense_product,
             change_pulse, refund, timeout_flag} !== 14'b1_000000_0_0_00_0_0_0) begin
            n_err++;
            $display("FAIL reset_outputs actual=%b required=%b",
                     {ready, credit, coin_reject, dispense_valid, dispense_product,
                      change_pulse, refund, timeout_flag}, 14'b1_000000_0_0_00_0_0_0);
        end
        rst_n = 1'b1;
    endtask

    // Price 15, coins 10+5: exact payment, no change
    task automatic test_exact_payment();
        int n_disp = 0; int n_chg = 0; int first = -1;
        logic [1:0] got_prod = 2'd0;
        apply_reset();
        tick(1'b1, 5'd15, 2'b01, 1'b0, 2'b00, 1'b0);
        n_cmp++;
        if (ready !== 1'b0) begin n_err++; $display("FAIL exact_ready_low actual=%b required=0", ready); end
        tick(1'b0, 5'd0, 2'd0, 1'b1, 2'b10, 1'b0);
        tick(1'b0, 5'd0, 2'd0, 1'b1, 2'b01, 1'b0);
        n_cmp++;
        if (credit !== 6'd15) begin n_err++; $display("FAIL exact_credit actual=%0d required=15", credit); end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 5'd0, 2'd0, 1'b0, 2'b00, 1'b0);
            if (dispense_valid) begin
                n_disp++; got_prod = dispense_product;
                if (first < 0) first = i;
            end
            if (change_pulse) n_chg++;
        end
        n_cmp++;
        if (n_disp !== 1) begin n_err++; $display("FAIL exact_dispense_count actual=%0d required=1", n_disp); end
        n_cmp++;
        if (first !== 0) begin n_err++; $display("FAIL exact_dispense_latency actual=%0d required=0", first); end
        n_cmp++;
        if (got_prod !== 2'b01) begin n_err++; $display("FAIL exact_product actual=%b required=01", got_prod); end
        n_cmp++;
        if (n_chg !== 0) begin n_err++; $display("FAIL exact_change_count actual=%0d required=0", n_chg); end
        n_cmp++;
        if (ready !== 1'b1 || credit !== 6'd0) begin
            n_err++; $display("FAIL exact_end_idle actual=%b/%0d required=1/0", ready, credit);
        end
    endtask

    // Price 20, coins 10+20: dispense, then 10 units of change
    task automatic test_change();
        int n_disp = 0; int n_chg = 0;
        logic [5:0] first_chg_credit = 6'h3f;
        logic [1:0] got_prod = 2'd0;
        apply_reset();
        tick(1'b1, 5'd20, 2'b10, 1'b0, 2'b00, 1'b0);
        tick(1'b0, 5'd0, 2'd0, 1'b1, 2'b10, 1'b0);
        tick(1'b0, 5'd0, 2'd0, 1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 5'd0, 2'd0, 1'b0, 2'b00, 1'b0);
            if (dispense_valid) begin n_disp++; got_prod = dispense_product; end
            if (change_pulse) begin
                if (n_chg == 0) first_chg_credit = credit;
                n_chg++;
            end
        end
        n_cmp++;
        if (n_disp !== 1 || got_prod !== 2'b10) begin
            n_err++; $display("FAIL change_dispense actual=%0d/%b required=1/10", n_disp, got_prod);
        end
        n_cmp++;
        if (first_chg_credit !== 6'd10) begin
            n_err++; $display("FAIL change_credit_after_dispense actual=%0d required=10", first_chg_credit);
        end
        n_cmp++;
        if (n_chg !== 2) begin n_err++; $display("FAIL change_pulse_count actual=%0d required=2", n_chg); end
        n_cmp++;
        if (ready !== 1'b1 || credit !== 6'd0) begin
            n_err++; $display("FAIL change_end_idle actual=%b/%0d required=1/0", ready, credit);
        end
    endtask

    // Price 25, one 5-unit coin, then silence until the refund
    task automatic test_timeout();
        int n_to = 0; int first = -1; int n_chg = 0; int n_ref = 0;
        apply_reset();
        tick(1'b1, 5'd25, 2'b11, 1'b0, 2'b00, 1'b0);
        tick(1'b0, 5'd0, 2'd0, 1'b1, 2'b01, 1'b0);
        for (int i = 1; i <= TO + 8; i++) begin
            tick(1'b0, 5'd0, 2'd0, 1'b0, 2'b00, 1'b0);
            if (timeout_flag) begin n_to++; if (first < 0) first = i; end
            if (change_pulse) n_chg++;
            if (refund) n_ref++;
        end
        n_cmp++;
        if (first !== TO) begin n_err++; $display("FAIL timeout_latency actual=%0d required=%0d", first, TO); end
        n_cmp++;
        if (n_to !== 1) begin n_err++; $display("FAIL timeout_pulse_width actual=%0d required=1", n_to); end
        n_cmp++;
        if (n_chg !== 1) begin n_err++; $display("FAIL timeout_refund_pulses actual=%0d required=1", n_chg); end
        n_cmp++;
        if (n_ref !== 2) begin n_err++; $display("FAIL timeout_refund_cycles actual=%0d required=2", n_ref); end
        n_cmp++;
        if (ready !== 1'b1) begin n_err++; $display("FAIL timeout_end_idle actual=%b required=1", ready); end
    endtask

    // A coin in the terminal timer cycle restarts the full timeout window
    task automatic test_timeout_edge();
        int first = -1; int n_chg = 0;
        apply_reset();
        tick(1'b1, 5'd25, 2'b00, 1'b0, 2'b00, 1'b0);
        tick(1'b0, 5'd0, 2'd0, 1'b1, 2'b01, 1'b0);
        repeat (TO - 1) tick(1'b0, 5'd0, 2'd0, 1'b0, 2'b00, 1'b0);
        tick(1'b0, 5'd0, 2'd0, 1'b1, 2'b01, 1'b0);
        n_cmp++;
        if (timeout_flag !== 1'b0 || refund !== 1'b0 || credit !== 6'd10) begin
            n_err++;
            $display("FAIL edge_coin_accepted actual=to%b/ref%b/cr%0d required=to0/ref0/cr10",
                     timeout_flag, refund, credit);
        end
        for (int i = 1; i <= TO + 8; i++) begin
            tick(1'b0, 5'd0, 2'd0, 1'b0, 2'b00, 1'b0);
            if (timeout_flag && first < 0) first = i;
            if (change_pulse) n_chg++;
        end
        n_cmp++;
        if (first !== TO) begin n_err++; $display("FAIL edge_timeout_latency actual=%0d required=%0d", first, TO); end
        n_cmp++;
        if (n_chg !== 2) begin n_err++; $display("FAIL edge_refund_pulses actual=%0d required=2", n_chg); end
    endtask

    task automatic test_rejects();
        apply_reset();
        tick(1'b0, 5'd0, 2'd0, 1'b1, 2'b10, 1'b0);
        n_cmp++;
        if (coin_reject !== 1'b1 || credit !== 6'd0 || ready !== 1'b1) begin
            n_err++; $display("FAIL reject_idle actual=rej%b/cr%0d required=rej1/cr0", coin_reject, credit);
        end
        tick(1'b1, 5'd25, 2'b01, 1'b0, 2'b00, 1'b0);
        tick(1'b0, 5'd0, 2'd0, 1'b1, 2'b00, 1'b0);
        n_cmp++;
        if (coin_reject !== 1'b1 || credit !== 6'd0) begin
            n_err++; $display("FAIL reject_code00 actual=rej%b/cr%0d required=rej1/cr0", coin_reject, credit);
        end
        tick(1'b0, 5'd0, 2'd0, 1'b1, 2'b11, 1'b0);
        n_cmp++;
        if (coin_reject !== 1'b0 || credit !== 6'd20) begin
            n_err++; $display("FAIL accept_20 actual=rej%b/cr%0d required=rej0/cr20", coin_reject, credit);
        end
        tick(1'b0, 5'd0, 2'd0, 1'b1, 2'b10, 1'b0);   // credit 30
        tick(1'b0, 5'd0, 2'd0, 1'b0, 2'b00, 1'b0);   // -> DISPENSE
        tick(1'b0, 5'd0, 2'd0, 1'b0, 2'b00, 1'b0);   // -> CHANGE, credit 5
        tick(1'b0, 5'd0, 2'd0, 1'b1, 2'b11, 1'b0);   // coin offered in CHANGE
        n_cmp++;
        if (coin_reject !== 1'b1 || credit !== 6'd0) begin
            n_err++; $display("FAIL reject_change actual=rej%b/cr%0d required=rej1/cr0", coin_reject, credit);
        end
    endtask

    task automatic test_reset_mid_change();
        apply_reset();
        tick(1'b1, 5'd5, 2'b10, 1'b0, 2'b00, 1'b0);
        tick(1'b0, 5'd0, 2'd0, 1'b1, 2'b11, 1'b0);
        tick(1'b0, 5'd0, 2'd0, 1'b0, 2'b00, 1'b0);
        tick(1'b0, 5'd0, 2'd0, 1'b0, 2'b00, 1'b0);   // in CHANGE, credit 15
        n_cmp++;
        if (change_pulse !== 1'b1 || credit !== 6'd15) begin
            n_err++; $display("FAIL midchange_setup actual=cp%b/cr%0d required=cp1/cr15", change_pulse, credit);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ready, credit, change_pulse, refund, dispense_valid} !== 10'b1_000000_0_0_0) begin
            n_err++; $display("FAIL midchange_async_reset actual=%b required=%b",
                              {ready, credit, change_pulse, refund, dispense_valid}, 10'b1_000000_0_0_0);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

`ifdef PAYMENT_CANCEL_EN
    task automatic test_cancel();
        int n_chg = 0; int n_to = 0;
        apply_reset();
        tick(1'b1, 5'd25, 2'b01, 1'b0, 2'b00, 1'b0);
        tick(1'b0, 5'd0, 2'd0, 1'b1, 2'b10, 1'b0);
        tick(1'b0, 5'd0, 2'd0, 1'b1, 2'b01, 1'b1);
        n_cmp++;
        if (coin_reject !== 1'b1 || refund !== 1'b1 || credit !== 6'd10 || timeout_flag !== 1'b0) begin
            n_err++; $display("FAIL cancel_entry actual=rej%b/ref%b/cr%0d/to%b required=rej1/ref1/cr10/to0",
                              coin_reject, refund, credit, timeout_flag);
        end
        if (change_pulse) n_chg++;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 5'd0, 2'd0, 1'b0, 2'b00, 1'b0);
            if (change_pulse) n_chg++;
            if (timeout_flag) n_to++;
        end
        n_cmp++;
        if (n_chg !== 2 || n_to !== 0) begin
            n_err++; $display("FAIL cancel_refund actual=pulses%0d/to%0d required=pulses2/to0", n_chg, n_to);
        end
    endtask
`endif

    // Randomized traffic against a behavioural model of the vending session
    task automatic test_random();
        int         mode;        // 0 waiting, 1 paying in, 2 releasing, 3 paying out
        bit         m_refund;
        int         m_credit, m_price, m_product, m_idle;
        bit         m_rej, m_to;
        int         value;
        bit         quiet;
        logic       pv, cv, cn;
        logic [4:0] pp;
        logic [1:0] pr, ct;
        logic [13:0] exp_v, act_v;

        apply_reset();
        mode = 0; m_refund = 0; m_credit = 0; m_price = 0; m_product = 0;
        m_idle = 0; m_rej = 0; m_to = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            exp_v = {mode == 0, 6'(m_credit), m_rej, mode == 2,
                     (mode == 2) ? 2'(m_product) : 2'b00,
                     (mode == 3) && (m_credit >= 5), (mode == 3) && m_refund, m_to};
            act_v = {ready, credit, coin_reject, dispense_valid, dispense_product,
                     change_pulse, refund, timeout_flag};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL random cyc=%0d outputs actual=%b required=%b", cyc, act_v, exp_v);
            end

            quiet = ((cyc / 200) % 2) == 1;
            pv = ($urandom_range(7, 0) == 0);
            pp = 5'($urandom_range(31, 0));
            pr = 2'($urandom_range(3, 0));
            cv = quiet ? ($urandom_range(99, 0) == 0) : ($urandom_range(3, 0) == 0);
            ct = 2'($urandom_range(3, 0));
`ifdef PAYMENT_CANCEL_EN
            cn = ($urandom_range(39, 0) == 0);
`else
            cn = 1'b0;
`endif
            value = (ct == 2'b01) ? 5 : (ct == 2'b10) ? 10 : (ct == 2'b11) ? 20 : 0;

            m_rej = 0; m_to = 0;
            case (mode)
                0: begin
                    m_rej = cv;
                    if (pv && pp != 0) begin
                        m_price = pp; m_product = pr; m_credit = 0; m_idle = 0; mode = 1;
                    end
                end
                1: begin
                    if (cn) begin
                        m_rej = cv; mode = 3; m_refund = 1;
                    end else if (m_credit >= m_price) begin
                        m_rej = cv; mode = 2;
                    end else if (cv && value != 0) begin
                        m_credit += value; m_idle = 0;
                    end else begin
                        m_rej = cv;
                        m_idle++;
                        if (m_idle == TO) begin mode = 3; m_refund = 1; m_to = 1; end
                    end
                end
                2: begin
                    m_rej = cv;
                    m_credit -= m_price;
                    if (m_credit == 0) mode = 0;
                    else begin mode = 3; m_refund = 0; end
                end
                default: begin
                    m_rej = cv;
                    if (m_credit >= 5) m_credit -= 5;
                    else begin m_credit = 0; mode = 0; m_refund = 0; end
                end
            endcase

            tick(pv, pp, pr, cv, ct, cn);
        end
    endtask

    initial begin
        test_reset();
        test_exact_payment();
        test_change();
        test_timeout();
        test_timeout_edge();
        test_rejects();
        test_reset_mid_change();
`ifdef PAYMENT_CANCEL_EN
        test_cancel();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
